// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - ALU/load/memory/register-file signal bundle for reg_writeback
interface reg_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        ld_busy;
  logic        ld_hazard;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
           mem_rsp_valid, mem_rsp_data, rs1, rs2,
    output alu_ready, ld_busy, ld_hazard, regwrite, rd, rd_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
           mem_rsp_valid, mem_rsp_data, rs1, rs2,
    input  alu_ready, ld_busy, ld_hazard, regwrite, rd, rd_data
  );
endinterface

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register writeback arbiter: one outstanding load plus ALU results
module reg_writeback (
  input logic          clk,
  input logic          rst_n,
  reg_writeback_if.slave bus
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  state_t      state_next;
  logic        ld_take;
  logic        rsp_take;
  logic        alu_take;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_offset;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_take    = 1'b0;
    rsp_take   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ld_issue) begin
          ld_take    = 1'b1;
          state_next = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rsp_valid) begin
          rsp_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are forced to their idle values while reset is asserted,
  // before the synchronous reset has had an edge to clear the state.
  assign bus.alu_ready = !rst_n || !rsp_take;
  assign bus.ld_busy   = rst_n && (state == WAIT_MEM);
  assign bus.ld_hazard = bus.ld_busy && (pend_rd != 5'd0) &&
                         ((bus.rs1 == pend_rd) || (bus.rs2 == pend_rd));
  assign alu_take      = bus.alu_valid && bus.alu_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_rd     <= 5'd0;
      pend_funct3 <= 3'd0;
      pend_offset <= 2'd0;
    end else if (ld_take) begin
      pend_rd     <= bus.ld_rd;
      pend_funct3 <= bus.ld_funct3;
      pend_offset <= bus.ld_offset;
    end
  end

  always_comb begin
    case (pend_offset)
      2'd0:    byte_sel = bus.mem_rsp_data[7:0];
      2'd1:    byte_sel = bus.mem_rsp_data[15:8];
      2'd2:    byte_sel = bus.mem_rsp_data[23:16];
      default: byte_sel = bus.mem_rsp_data[31:24];
    endcase
    half_sel = pend_offset[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    case (pend_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = bus.mem_rsp_data;
    endcase
  end

  // Writes to x0 still update rd/rd_data but never raise regwrite.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.regwrite <= 1'b0;
      bus.rd       <= 5'd0;
      bus.rd_data  <= 32'd0;
    end else if (rsp_take) begin
      bus.regwrite <= (pend_rd != 5'd0);
      bus.rd       <= pend_rd;
      bus.rd_data  <= ld_data;
    end else if (alu_take) begin
      bus.regwrite <= (bus.alu_rd != 5'd0);
      bus.rd       <= bus.alu_rd;
      bus.rd_data  <= bus.alu_data;
    end else begin
      bus.regwrite <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed and random checks of reg_writeback against a queue-based model
module tb_reg_writeback;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  ld_t         pend_q[$];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] fmt(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = 5'd0;
    bus.alu_data      = 32'd0;
    bus.ld_issue      = 1'b0;
    bus.ld_rd         = 5'd0;
    bus.ld_funct3     = 3'd0;
    bus.ld_offset     = 2'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    bus.rs1           = 5'd0;
    bus.rs2           = 5'd0;
  endtask

  // Checks combinational outputs for the current inputs, advances the model
  // across one rising edge, then checks the registered write port.
  task automatic cycle();
    logic busy;
    logic hazard;
    ld_t  ld;
    #1;
    busy   = rst_n && (pend_q.size() != 0);
    hazard = 1'b0;
    if (busy)
      hazard = (pend_q[0].rd != 5'd0) && (bus.rs1 == pend_q[0].rd || bus.rs2 == pend_q[0].rd);
    check("alu_ready", bus.alu_ready, !(busy && bus.mem_rsp_valid));
    check("ld_busy", bus.ld_busy, busy);
    check("ld_hazard", bus.ld_hazard, hazard);
    if (!rst_n) begin
      pend_q.delete();
      m_rw   = 1'b0;
      m_rd   = 5'd0;
      m_data = 32'd0;
    end else begin
      if (busy && bus.mem_rsp_valid) begin
        ld     = pend_q.pop_front();
        m_rd   = ld.rd;
        m_data = fmt(ld.f3, ld.off, bus.mem_rsp_data);
        m_rw   = (ld.rd != 5'd0);
      end else if (bus.alu_valid) begin
        m_rd   = bus.alu_rd;
        m_data = bus.alu_data;
        m_rw   = (bus.alu_rd != 5'd0);
      end else begin
        m_rw   = 1'b0;
      end
      if (!busy && bus.ld_issue) begin
        ld.rd  = bus.ld_rd;
        ld.f3  = bus.ld_funct3;
        ld.off = bus.ld_offset;
        pend_q.push_back(ld);
      end
    end
    @(posedge clk);
    #1;
    check("regwrite", bus.regwrite, m_rw);
    check("rd", bus.rd, m_rd);
    check("rd_data", bus.rd_data, m_data);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    n_assert = 0;
    n_fail   = 0;
    m_rw     = 1'b0;
    m_rd     = 5'd0;
    m_data   = 32'd0;
    clr();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    cycle();
    check("alu_rd5", bus.rd, 5'd5);
    check("alu_data", bus.rd_data, 32'h1234);
    clr();
    cycle();

    // LB / LBU from byte 2
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd7; bus.ld_funct3 = 3'b000; bus.ld_offset = 2'd2;
    cycle();
    clr();
    cycle();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h80FF0011;
    cycle();
    check("lb_value", bus.rd_data, 32'hFFFFFFFF);
    clr();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd7; bus.ld_funct3 = 3'b100; bus.ld_offset = 2'd2;
    cycle();
    clr();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h80FF0011;
    cycle();
    check("lbu_value", bus.rd_data, 32'h000000FF);
    clr();

    // load response beats ALU; ALU follows one cycle later
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd3; bus.ld_funct3 = 3'b010;
    cycle();
    clr();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hAABBCCDD;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h55;
    cycle();
    check("prio_rd3", bus.rd, 5'd3);
    check("prio_lw", bus.rd_data, 32'hAABBCCDD);
    bus.mem_rsp_valid = 1'b0;
    cycle();
    check("prio_rd4", bus.rd, 5'd4);
    clr();
    cycle();

    // hazard detection
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
    cycle();
    clr();
    bus.rs1 = 5'd9;
    cycle();
    check("haz_rs1", bus.ld_hazard, 1'b1);
    bus.rs1 = 5'd10; bus.rs2 = 5'd10;
    #1;
    check("haz_none", bus.ld_hazard, 1'b0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1;
    cycle();
    clr();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd0;
    cycle();
    clr();
    #1;
    check("haz_x0", bus.ld_hazard, 1'b0);
    check("busy_x0", bus.ld_busy, 1'b1);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h77;
    cycle();
    check("ld_x0_drop", bus.regwrite, 1'b0);
    clr();

    // ALU write to x0 dropped
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    cycle();
    check("alu_x0_drop", bus.regwrite, 1'b0);
    clr();
    cycle();

    // reset abandons a pending load
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd12;
    cycle();
    clr();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h12345678;
    cycle();
    check("rst_busy", bus.ld_busy, 1'b0);
    check("rst_nowrite", bus.regwrite, 1'b0);
    clr();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n             = ($urandom_range(0, 99) != 0);
      bus.alu_valid     = ($urandom_range(0, 99) < 50);
      bus.alu_rd        = 5'($urandom_range(0, 31));
      bus.alu_data      = $urandom;
      bus.ld_issue      = ($urandom_range(0, 99) < 35);
      bus.ld_rd         = 5'($urandom_range(0, 7));
      bus.ld_funct3     = 3'($urandom_range(0, 7));
      bus.ld_offset     = 2'($urandom_range(0, 3));
      bus.mem_rsp_valid = ($urandom_range(0, 99) < 40);
      bus.mem_rsp_data  = $urandom;
      bus.rs1           = 5'($urandom_range(0, 7));
      bus.rs2           = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
